// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: ALU control codes, alu_op/funct encodings and FSM states shared by ID and EX stages.
package alu_ctrl_pkg;
  localparam logic [3:0] ALU_AND = 4'b0000, ALU_OR = 4'b0001, ALU_ADD = 4'b0010, ALU_XOR = 4'b0011;
  localparam logic [3:0] ALU_SUB = 4'b0110, ALU_SLT = 4'b0111, ALU_SLL = 4'b1000, ALU_SRL = 4'b1001;
  localparam logic [3:0] ALU_SRA = 4'b1010, ALU_SLTU = 4'b1011, ALU_NOR = 4'b1100, ALU_LUI = 4'b1101;
  localparam logic [2:0] OP_ADD = 3'b000, OP_SUB = 3'b001, OP_RTYPE = 3'b010, OP_AND = 3'b011;
  localparam logic [2:0] OP_OR = 3'b100, OP_SLT = 3'b101, OP_LUI = 3'b110, OP_RSVD = 3'b111;
  localparam logic [5:0] F_SLL = 6'b000000, F_SRL = 6'b000010, F_SRA = 6'b000011;
  localparam logic [5:0] F_SLLV = 6'b000100, F_SRLV = 6'b000110, F_SRAV = 6'b000111;
  localparam logic [5:0] F_ADD = 6'b100000, F_ADDU = 6'b100001, F_SUB = 6'b100010, F_SUBU = 6'b100011;
  localparam logic [5:0] F_AND = 6'b100100, F_OR = 6'b100101, F_XOR = 6'b100110, F_NOR = 6'b100111;
  localparam logic [5:0] F_SLT = 6'b101010, F_SLTU = 6'b101011, F_MFHI = 6'b010000, F_MFLO = 6'b010010;
  localparam logic [5:0] F_MULT = 6'b011000, F_MULTU = 6'b011001, F_DIV = 6'b011010, F_DIVU = 6'b011011;
  localparam logic [1:0] MD_MULT = 2'b00, MD_MULTU = 2'b01, MD_DIV = 2'b10, MD_DIVU = 2'b11;
  localparam logic [1:0] HILO_NONE = 2'b00, HILO_HI = 2'b01, HILO_LO = 2'b10;
  typedef enum logic {S_IDLE, S_BUSY} state_t;
endpackage

// File: rtl/md_latency_counter.sv
// md_latency_counter: loadable down-counter timing a mul/div operation; saturates at zero.
module md_latency_counter #(
  parameter int MD_LATENCY = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  input  logic i_dec,
  output logic o_zero
);
  localparam int CW = $clog2(MD_LATENCY + 1);
  logic [CW-1:0] r_cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_cnt <= '0;
    else if (i_load) r_cnt <= CW'(MD_LATENCY - 1);
    else if (i_dec && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
  assign o_zero = r_cnt == '0;
endmodule

// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq: registered ALU control decode with a mul/div launch-and-stall sequencer.
module alu_ctrl_seq
  import alu_ctrl_pkg::*;
#(
  parameter int SIG_W      = 4,
  parameter int MD_LATENCY = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             flush,
  input  logic             valid_in,
  input  logic [2:0]       alu_op,
  input  logic [5:0]       funct,
  output logic [SIG_W-1:0] alu_sig,
  output logic             shamt_sel,
  output logic             md_start,
  output logic [1:0]       md_op,
  output logic [1:0]       hilo_rd,
  output logic             stall,
  output logic             illegal
);
  state_t     r_state;
  logic [3:0] w_sig;
  logic       w_shamt, w_md, w_ill, w_launch, w_zero;
  logic [1:0] w_hilo;
  always_comb begin
    w_sig = ALU_ADD;
    w_shamt = 1'b0;
    w_hilo = HILO_NONE;
    w_md = 1'b0;
    w_ill = 1'b0;
    case (alu_op)
      OP_ADD:   w_sig = ALU_ADD;
      OP_SUB:   w_sig = ALU_SUB;
      OP_AND:   w_sig = ALU_AND;
      OP_OR:    w_sig = ALU_OR;
      OP_SLT:   w_sig = ALU_SLT;
      OP_LUI:   w_sig = ALU_LUI;
      OP_RSVD:  w_ill = 1'b1;
      OP_RTYPE:
        case (funct)
          F_SLL:                       {w_sig, w_shamt} = {ALU_SLL, 1'b1};
          F_SRL:                       {w_sig, w_shamt} = {ALU_SRL, 1'b1};
          F_SRA:                       {w_sig, w_shamt} = {ALU_SRA, 1'b1};
          F_SLLV:                      w_sig = ALU_SLL;
          F_SRLV:                      w_sig = ALU_SRL;
          F_SRAV:                      w_sig = ALU_SRA;
          F_ADD, F_ADDU:               w_sig = ALU_ADD;
          F_SUB, F_SUBU:               w_sig = ALU_SUB;
          F_AND:                       w_sig = ALU_AND;
          F_OR:                        w_sig = ALU_OR;
          F_XOR:                       w_sig = ALU_XOR;
          F_NOR:                       w_sig = ALU_NOR;
          F_SLT:                       w_sig = ALU_SLT;
          F_SLTU:                      w_sig = ALU_SLTU;
          F_MFHI:                      w_hilo = HILO_HI;
          F_MFLO:                      w_hilo = HILO_LO;
          F_MULT, F_MULTU, F_DIV, F_DIVU: w_md = 1'b1;
          default:                     w_ill = 1'b1;
        endcase
      default:  w_ill = 1'b1;
    endcase
  end
  assign w_launch = r_state == S_IDLE && en && !flush && valid_in && w_md;
  md_latency_counter #(.MD_LATENCY(MD_LATENCY)) u_cnt (
    .clk(clk), .rst(rst), .i_load(w_launch), .i_dec(r_state == S_BUSY), .o_zero(w_zero)
  );
  // Flush squashes the decode registers in either state; BUSY itself always runs to completion.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= S_IDLE;
      alu_sig <= SIG_W'(ALU_ADD);
      shamt_sel <= 1'b0;
      md_start <= 1'b0;
      md_op <= MD_MULT;
      hilo_rd <= HILO_NONE;
      stall <= 1'b0;
      illegal <= 1'b0;
    end else begin
      md_start <= 1'b0;
      illegal <= 1'b0;
      if (en && flush) begin
        alu_sig <= SIG_W'(ALU_ADD);
        shamt_sel <= 1'b0;
        hilo_rd <= HILO_NONE;
      end else if (en && r_state == S_IDLE) begin
        alu_sig <= SIG_W'(w_sig);
        shamt_sel <= w_shamt;
        hilo_rd <= valid_in ? w_hilo : HILO_NONE;
        illegal <= valid_in && w_ill;
      end
      if (w_launch) begin
        md_start <= 1'b1;
        md_op <= funct[1:0];
        stall <= 1'b1;
        r_state <= S_BUSY;
      end else if (r_state == S_BUSY && w_zero) begin
        stall <= 1'b0;
        r_state <= S_IDLE;
      end
    end
endmodule

// File: doc/alu_ctrl_seq.md
# alu_ctrl_seq

Registered, parametrised ALU control unit for the MIPS pipeline's ID/EX boundary. It decodes a widened ALUOp and the R-type funct field into a registered ALU signal plus shift-source select. It adds a small sequencer for the HI/LO instructions: mult, multu, div and divu launch an external multi-cycle multiply/divide unit, and the block stalls the pipeline for a parametrised latency. It also flags illegal funct codes.

## Interface
- `SIG_W`, default 4: ALU signal width; must be ≥ 4, codes zero-extended.
- `MD_LATENCY`, default 32: cycles the mul/div unit needs per operation; must be ≥ 1.
- `clk` in, 1: pipeline clock; single clock domain.
- `rst` in, 1: asynchronous, active-high reset.
- `en` in, 1: pipeline advance from the hazard unit; inputs are sampled only when high.
- `flush` in, 1: squash the current decode; registered ALU outputs return to reset values.
- `valid_in` in, 1: the ID-stage instruction is valid.
- `alu_op` in, 3: 000 add, 001 sub, 010 R-type, 011 and, 100 or, 101 slt, 110 lui, 111 reserved.
- `funct` in, 6: R-type function field.
- `alu_sig` out, SIG_W: registered ALU control code.
- `shamt_sel` out, 1: 1 selects the shamt field as the shift amount; 0 selects rs (variable shifts).
- `md_start` out, 1: one-cycle pulse that launches the mul/div unit.
- `md_op` out, 2: 00 mult, 01 multu, 10 div, 11 divu; valid with `md_start`.
- `hilo_rd` out, 2: 01 mfhi, 10 mflo, 00 none.
- `stall` out, 1: the pipeline must hold while high.
- `illegal` out, 1: one-cycle flag for an unsupported funct under alu_op 010, or for alu_op 111.

## Operation
- ALU codes:
  - AND 0000, OR 0001, ADD 0010, XOR 0011, SUB 0110, SLT 0111.
  - SLL 1000, SRL 1001, SRA 1010, SLTU 1011, NOR 1100, LUI 1101.
- alu_op mapping: non-010 values map directly to ADD, SUB, AND, OR, SLT or LUI. alu_op 111 gives ADD with `illegal`.
- R-type funct mapping:
  - 000000 sll, 000010 srl, 000011 sra: `shamt_sel`=1.
  - 000100 sllv, 000110 srlv, 000111 srav: same codes, `shamt_sel`=0.
  - 100000/100001 ADD; 100010/100011 SUB.
  - 100100 AND, 100101 OR, 100110 XOR, 100111 NOR.
  - 101010 SLT, 101011 SLTU.
  - 010000 mfhi, 010010 mflo: `alu_sig`=ADD, `hilo_rd` set.
  - 011000–011011 mult/multu/div/divu: `md_op` = funct[1:0], `alu_sig`=ADD.
  - Any other funct: ADD with `illegal`=1.
- FSM, two states:
  - IDLE: on `valid_in`&`en`&!`flush` with a mul/div funct, pulse `md_start`, load the counter with MD_LATENCY-1, go to BUSY.
  - BUSY: `stall`=1; the counter decrements each cycle. When the counter is 0, go to IDLE and drop `stall`. Inputs are ignored and `alu_sig`/`shamt_sel`/`hilo_rd` hold.
- `flush` clears the decode registers but does not abort BUSY; the in-flight mul/div completes.
- mfhi/mflo arriving while BUSY is not accepted (the pipeline is stalled). It is decoded on the first `en` cycle after `stall` falls.
- Counter width is $clog2(MD_LATENCY+1); the counter never wraps, and it saturates at 0 in IDLE.
- `rst` at any time, including mid-BUSY, forces IDLE, counter 0 and reset outputs. The external unit is reset by the same `rst`.

## Timing
- Reset values: `alu_sig`=0010 (zero-extended), `shamt_sel`=0, `md_start`=0, `md_op`=00, `hilo_rd`=00, `stall`=0, `illegal`=0.
- Decode latency is 1 cycle: inputs sampled at edge N appear at edge N+1.
- With `en` low, all outputs hold and `md_start`/`illegal` return to 0.
- `md_start` and `stall` rise at the same edge. `stall` stays high exactly MD_LATENCY cycles; for MD_LATENCY=1, `stall` is high for one cycle.
- Simultaneous `flush`+`en`: `flush` wins and nothing is launched.

## Structure
- Shared package `alu_ctrl_pkg` holds:
  - ALU code localparams;
  - alu_op encodings;
  - funct constants;
  - md_op and hilo_rd encodings;
  - FSM state typedef.
  The existing EX-stage ALU imports the same codes.
- One natural sub-module, `md_latency_counter`: load/decrement/zero-flag down-counter parametrised by MD_LATENCY.

## Test plan
- Reset then alu_op=010, funct=100111, en=1 → next edge `alu_sig`=1100, `illegal`=0, `stall`=0.
- funct=000011, then funct=000111 → `alu_sig`=1010 both times; `shamt_sel`=1 then 0.
- MD_LATENCY=4, funct=011010 → `md_start`=1 for one cycle with `md_op`=10; `stall` high exactly 4 cycles; an ADD presented during BUSY decodes only after `stall` falls.
- alu_op=010, funct=111111 → `alu_sig`=0010, `illegal`=1 for one cycle. alu_op=111 behaves the same.
- `rst` asserted in cycle 2 of a 32-cycle BUSY, asynchronously off-edge → `stall`=0 immediately, all outputs at reset values, and the next mult launches normally.
- `flush` with a mult on the inputs → no `md_start`, `stall`=0. `flush` during BUSY → `alu_sig`=0010, but `stall` persists to its full count.
